// File: rtl/stopwatch_tick_counter.sv
// MM:SS BCD stopwatch driven by the divider's slow square wave, with run/pause/adjust modes.
// Define BLINK_EN to blink the selected digit pair in ADJUST; otherwise blank is tied low.
module stopwatch_tick_counter #(
    parameter int TICKS_PER_COUNT = 2,
    parameter int PRE_W           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    output logic       tick_pulse,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       wrap,
    output logic [1:0] blank
);

    typedef enum logic [1:0] {RUN, PAUSED, ADJUST} state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_COUNT - 1);

    state_t           state;
    logic             s1, s2, s3;
    logic [1:0]       warm;
    logic [PRE_W-1:0] pre;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            warm       <= '0;
            tick_pulse <= 1'b0;
            wrap       <= 1'b0;
            pre        <= '0;
            sec_ones   <= '0;
            sec_tens   <= '0;
            min_ones   <= '0;
            min_tens   <= '0;
            state      <= RUN;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
            if (warm != 2'd3)
                warm <= warm + 2'd1;
            // Until s3 holds a real post-reset sample, a level already high is not an edge.
            tick_pulse <= s2 & ~s3 & (warm == 2'd3);
            wrap       <= 1'b0;

            if (state == ADJUST)
                pre <= '0;

            if (tick_pulse) begin
                case (state)
                    RUN: begin
                        if (pre != PRE_LAST) begin
                            pre <= pre + 1'b1;
                        end else begin
                            pre <= '0;
                            if (sec_ones != 4'd9) begin
                                sec_ones <= sec_ones + 4'd1;
                            end else begin
                                sec_ones <= '0;
                                if (sec_tens != 4'd5) begin
                                    sec_tens <= sec_tens + 4'd1;
                                end else begin
                                    sec_tens <= '0;
                                    if (min_ones != 4'd9) begin
                                        min_ones <= min_ones + 4'd1;
                                    end else begin
                                        min_ones <= '0;
                                        if (min_tens != 4'd5) begin
                                            min_tens <= min_tens + 4'd1;
                                        end else begin
                                            min_tens <= '0;
                                            wrap     <= 1'b1;
                                        end
                                    end
                                end
                            end
                        end
                    end
                    ADJUST: begin
                        // Selected field wraps 59 -> 00 on its own; no carry into the other field.
                        if (!sel) begin
                            if (sec_ones != 4'd9) begin
                                sec_ones <= sec_ones + 4'd1;
                            end else begin
                                sec_ones <= '0;
                                sec_tens <= (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
                            end
                        end else begin
                            if (min_ones != 4'd9) begin
                                min_ones <= min_ones + 4'd1;
                            end else begin
                                min_ones <= '0;
                                min_tens <= (min_tens == 4'd5) ? 4'd0 : min_tens + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            if (adj && state != ADJUST) begin
                state <= ADJUST;
            end else if (state == ADJUST) begin
                if (!adj)
                    state <= RUN;
            end else if (pause_btn) begin
                state <= (state == RUN) ? PAUSED : RUN;
            end
        end
    end

`ifdef BLINK_EN
    logic       sel_q;
    logic [1:0] blink;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= 1'b0;
            blink <= '0;
        end else begin
            sel_q <= sel;
            if (state != ADJUST || !adj || sel != sel_q)
                blink <= '0;
            else if (tick_pulse)
                blink <= sel ? {~blink[1], 1'b0} : {1'b0, ~blink[0]};
        end
    end

    assign blank = blink;
`else
    assign blank = '0;
`endif

endmodule
